// File: rtl/pipeline_hazard_ctrl.sv
// Purpose : stall/flush sequencer for the 5-stage pipeline (load-use, HI/LO mul/div, EX branch, dmem wait).
// Latency : control outputs are combinational from inputs + registered state; muldiv_done/mem_timeout registered.
// Backpr. : ext_mem_stall freezes every pipeline register; hazards hold PC and IF/ID and insert an ID/EX bubble.
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   id_*                          - ID-stage instruction operands and class
//   id_ex_mem_read, id_ex_rd      - load currently in ID/EX and its destination
//   branch_taken_ex, ext_mem_stall- EX redirect and data-memory wait
//   *_write_en, if_id_flush, id_ex_bubble - pipeline register controls
//   muldiv_busy/done, mem_timeout - scoreboard and watchdog status
//   perf_stall_cnt/perf_flush_cnt - performance counters
// Optional: define HAZ_PERF_CNT_EN to build the performance counters; otherwise they read 0.
module pipeline_hazard_ctrl #(
    parameter int MULDIV_LATENCY = 4,
    parameter int MEM_TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_reads_hilo,
    input  logic        id_muldiv,
    input  logic        id_ex_mem_read,
    input  logic [4:0]  id_ex_rd,
    input  logic        branch_taken_ex,
    input  logic        ext_mem_stall,
    output logic        pc_write_en,
    output logic        if_id_write_en,
    output logic        id_ex_write_en,
    output logic        ex_mem_write_en,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        muldiv_busy,
    output logic        muldiv_done,
    output logic        mem_timeout,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    localparam int BUSY_W = (MULDIV_LATENCY >= 1) ? $clog2(MULDIV_LATENCY + 1) : 1;
    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(MULDIV_LATENCY);
    localparam logic [BUSY_W-1:0] BUSY_ONE  = BUSY_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;

    logic busy_raw;
    logic load_use;
    logic hilo_haz;
    logic issue;

    assign busy_raw = (busy_cnt_q != '0);

    // id_ex_rd==0 is $zero: a load into it never creates a dependency.
    assign load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                      ((id_uses_rs && (id_ex_rd == id_rs)) ||
                       (id_uses_rt && (id_ex_rd == id_rt)));

    // A second mul/div is held as well, so the scoreboard only ever tracks one op.
    assign hilo_haz = busy_raw && id_valid && (id_reads_hilo || id_muldiv);

    always_comb begin
        pc_write_en     = 1'b1;
        if_id_write_en  = 1'b1;
        id_ex_write_en  = 1'b1;
        ex_mem_write_en = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_bubble    = 1'b0;
        issue           = 1'b0;
        if (rst) begin
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            id_ex_write_en  = 1'b0;
            ex_mem_write_en = 1'b0;
            if_id_flush     = 1'b1;
            id_ex_bubble    = 1'b1;
        end else if (ext_mem_stall) begin
            // Full freeze; a taken branch stays in EX and is acted on once memory is ready.
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            id_ex_write_en  = 1'b0;
            ex_mem_write_en = 1'b0;
        end else if (branch_taken_ex) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use || hilo_haz) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
        end else begin
            issue = id_valid;
        end
    end

    always_comb begin
        busy_cnt_d = busy_cnt_q;
        if (issue && id_muldiv) begin
            busy_cnt_d = BUSY_LOAD;
        end else if (busy_raw) begin
            busy_cnt_d = busy_cnt_q - BUSY_ONE;
        end
        // Pulse lands in the cycle the counter reads zero again.
        done_d = (busy_cnt_q == BUSY_ONE);

        wait_cnt_d = '0;
        timeout_d  = timeout_q;
        if ((MEM_TIMEOUT > 0) && ext_mem_stall) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
            if (wait_cnt_q == WAIT_LAST) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt_q <= '0;
            wait_cnt_q <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            busy_cnt_q <= busy_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    // Status is forced low for the whole reset cycle, not just after the edge.
    assign muldiv_busy = busy_raw && !rst;
    assign muldiv_done = done_q && !rst;
    assign mem_timeout = timeout_q && !rst;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
    logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

    always_comb begin
        perf_stall_cnt_d = perf_stall_cnt_q;
        perf_flush_cnt_d = perf_flush_cnt_q;
        if (!pc_write_en) begin
            perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
        end
        if (!ext_mem_stall && branch_taken_ex) begin
            perf_flush_cnt_d = perf_flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt_q <= '0;
            perf_flush_cnt_q <= '0;
        end else begin
            perf_stall_cnt_q <= perf_stall_cnt_d;
            perf_flush_cnt_q <= perf_flush_cnt_d;
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_q;
    assign perf_flush_cnt = perf_flush_cnt_q;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule
